// File: rtl/oc8051_memguard.sv
// oc8051_memguard
//   Shared-memory access controller placed after the dual-core arbiter.
//   It takes one arbitrated request at a time and runs it against a
//   single-port SRAM, adding WAIT_STATES extra cycles per access.
//   Unprivileged accesses that fall inside [PROT_LO, PROT_HI] are blocked:
//   the SRAM is never strobed, the requester gets an immediate ack, and the
//   violation is logged (address, PC, saturating count).
//
//   State table
//     IDLE   | waiting for stb; accepts and classifies a request
//     ACCESS | SRAM strobe held for WAIT_STATES+1 cycles
//     DONE   | one-cycle ack for a completed SRAM access
//     FAULT  | one-cycle ack + viol for a blocked access; log updated
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   stb, wr, addr,        arbitrated request (stb only honoured in IDLE)
//   data_in, priv_lvl,
//   dpc_ot
//   ack, data_out         completion pulse and registered read data
//   mem_addr, mem_wdata,  SRAM interface
//   mem_rdata, mem_we,
//   mem_re
//   viol, viol_addr,      violation pulse and log
//   viol_pc, viol_cnt
module oc8051_memguard #(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] PROT_LO     = 16'hF000,
  parameter logic [15:0] PROT_HI     = 16'hFFFF,
  parameter logic [7:0]  FAULT_DATA  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        priv_lvl,
  input  logic [15:0] dpc_ot,
  output logic        ack,
  output logic [7:0]  data_out,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic        viol,
  output logic [15:0] viol_addr,
  output logic [15:0] viol_pc,
  output logic [7:0]  viol_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_pc;
  logic [7:0]  r_data_out;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic [15:0] r_viol_addr;
  logic [15:0] r_viol_pc;
  logic [7:0]  r_viol_cnt;

  logic w_blocked;

  assign w_blocked = !priv_lvl && (addr >= PROT_LO) && (addr <= PROT_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_addr      <= 16'd0;
      r_pc        <= 16'd0;
      r_data_out  <= 8'd0;
      r_mem_addr  <= 16'd0;
      r_mem_wdata <= 8'd0;
      r_viol_addr <= 16'd0;
      r_viol_pc   <= 16'd0;
      r_viol_cnt  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (stb) begin
            r_wr   <= wr;
            r_addr <= addr;
            r_pc   <= dpc_ot;
            if (w_blocked) begin
              r_state <= S_FAULT;
              // Fault data is loaded here so it is already valid alongside the ack.
              if (!wr) r_data_out <= FAULT_DATA;
            end else begin
              r_state     <= S_ACCESS;
              r_cnt       <= LP_WS;
              r_mem_addr  <= addr;
              r_mem_wdata <= data_in;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_wr) r_data_out <= mem_rdata;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_FAULT: begin
          r_viol_addr <= r_addr;
          r_viol_pc   <= r_pc;
          if (r_viol_cnt != 8'hFF) r_viol_cnt <= r_viol_cnt + 8'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes, ack and viol decode straight from state so that an async reset
  // drops them in the same instant.
  assign mem_re    = (r_state == S_ACCESS) && !r_wr;
  assign mem_we    = (r_state == S_ACCESS) && r_wr;
  assign ack       = (r_state == S_DONE) || (r_state == S_FAULT);
  assign viol      = (r_state == S_FAULT);
  assign data_out  = r_data_out;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign viol_addr = r_viol_addr;
  assign viol_pc   = r_viol_pc;
  assign viol_cnt  = r_viol_cnt;

endmodule

// File: tb/tb_oc8051_memguard.sv
module tb_oc8051_memguard;

  localparam int          WS    = 2;
  localparam logic [15:0] P_LO  = 16'hF000;
  localparam logic [15:0] P_HI  = 16'hFFFF;
  localparam logic [7:0]  F_DAT = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, wr, priv_lvl;
  logic [15:0] addr, dpc_ot;
  logic [7:0]  data_in, mem_rdata;
  logic        ack, mem_we, mem_re, viol;
  logic [7:0]  data_out, mem_wdata, viol_cnt;
  logic [15:0] mem_addr, viol_addr, viol_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the architecturally visible registers
  logic [7:0]  m_dout;
  logic [7:0]  m_vcnt;
  logic [15:0] m_vaddr, m_vpc;

  oc8051_memguard #(
    .WAIT_STATES(WS), .PROT_LO(P_LO), .PROT_HI(P_HI), .FAULT_DATA(F_DAT)
  ) dut (
    .clk(clk), .rst(rst), .stb(stb), .wr(wr), .addr(addr),
    .data_in(data_in), .priv_lvl(priv_lvl), .dpc_ot(dpc_ot),
    .ack(ack), .data_out(data_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_re(mem_re), .viol(viol), .viol_addr(viol_addr),
    .viol_pc(viol_pc), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".data_out"},  {24'd0, data_out},  {24'd0, m_dout});
    chk({tag, ".viol_cnt"},  {24'd0, viol_cnt},  {24'd0, m_vcnt});
    chk({tag, ".viol_addr"}, {16'd0, viol_addr}, {16'd0, m_vaddr});
    chk({tag, ".viol_pc"},   {16'd0, viol_pc},   {16'd0, m_vpc});
  endtask

  // Issue one request from an IDLE negedge and follow it to completion.
  // Returns at the negedge of the cycle after the ack.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic p, input logic [15:0] pc, input logic [7:0] rd);
    logic blk;
    int   strobes, first_s, last_s, bad_dir, bad_bus, ack_cyc, n_ack, n_viol, viol_cyc;
    blk = !p && (a >= P_LO) && (a <= P_HI);
    strobes = 0; first_s = 0; last_s = 0; bad_dir = 0; bad_bus = 0;
    ack_cyc = 0; n_ack = 0; n_viol = 0; viol_cyc = 0;
    mem_rdata = rd;
    stb = 1'b1; wr = w; addr = a; data_in = d; priv_lvl = p; dpc_ot = pc;
    @(posedge clk);
    #1;
    stb = 1'b0;
    wr = 1'($urandom); addr = 16'($urandom); data_in = 8'($urandom);
    priv_lvl = 1'($urandom); dpc_ot = 16'($urandom);
    for (int k = 1; k <= 40 && ack_cyc == 0; k++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        strobes++;
        if (first_s == 0) first_s = k;
        last_s = k;
        if (mem_re !== !w || mem_we !== w) bad_dir++;
        if (mem_addr !== a || (w && mem_wdata !== d)) bad_bus++;
      end
      if (viol) begin n_viol++; viol_cyc = k; end
      if (ack) begin n_ack++; ack_cyc = k; end
    end
    chk("ack_latency", ack_cyc, blk ? 1 : WS + 2);
    chk("strobe_cycles", strobes, blk ? 0 : WS + 1);
    if (!blk) begin
      chk("strobe_first", first_s, 1);
      chk("strobe_last", last_s, WS + 1);
    end
    chk("strobe_dir", bad_dir, 0);
    chk("sram_bus", bad_bus, 0);
    chk("viol_pulses", n_viol, blk ? 1 : 0);
    if (blk) chk("viol_with_ack", viol_cyc, ack_cyc);
    @(negedge clk);
    chk("ack_width", ack, 1'b0);
    chk("viol_width", viol, 1'b0);
    if (!w) m_dout = blk ? F_DAT : rd;
    if (blk) begin
      m_vaddr = a;
      m_vpc   = pc;
      if (m_vcnt != 8'hFF) m_vcnt = m_vcnt + 8'd1;
    end
    chk_regs("post");
  endtask

  initial begin
    int sel, n_ack;
    logic [15:0] ra;
    rst = 1'b1; stb = 1'b0; wr = 1'b0; addr = 16'd0; data_in = 8'd0;
    priv_lvl = 1'b0; dpc_ot = 16'd0; mem_rdata = 8'd0;
    m_dout = 8'd0; m_vcnt = 8'd0; m_vaddr = 16'd0; m_vpc = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ack", ack, 1'b0);
    chk("rst.mem_re", mem_re, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.viol", viol, 1'b0);
    chk("rst.mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst.mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk_regs("rst");

    // directed cases
    do_req(1'b0, 16'h0100, 8'h00, 1'b0, 16'h0010, 8'h5A);
    chk("dir.read_data", {24'd0, data_out}, 32'h5A);
    do_req(1'b1, 16'h0200, 8'hC3, 1'b0, 16'h0020, 8'h11);
    chk("dir.write_keeps", {24'd0, data_out}, 32'h5A);
    do_req(1'b0, 16'hF000, 8'h00, 1'b0, 16'h1234, 8'h77);
    chk("dir.fault_cnt", {24'd0, viol_cnt}, 32'd1);
    chk("dir.fault_pc", {16'd0, viol_pc}, 32'h1234);
    do_req(1'b1, 16'hFFFF, 8'h3C, 1'b1, 16'h0040, 8'h00);
    do_req(1'b0, 16'hEFFF, 8'h00, 1'b0, 16'h0050, 8'hA5);
    chk("dir.below_window", {24'd0, data_out}, 32'hA5);
    chk("dir.cnt_unchanged", {24'd0, viol_cnt}, 32'd1);

    // saturation of the violation counter
    for (int i = 0; i < 256; i++)
      do_req(1'b1, 16'hF800, 8'(i), 1'b0, 16'(i), 8'h00);
    chk("sat.viol_cnt", {24'd0, viol_cnt}, 32'hFF);

    // randomized traffic, biased toward the window edges
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: ra = P_LO;
        1: ra = P_LO - 16'd1;
        2: ra = P_HI;
        3: ra = P_LO + 16'($urandom_range(0, 255));
        default: ra = 16'($urandom);
      endcase
      do_req(1'($urandom), ra, 8'($urandom), 1'($urandom), 16'($urandom), 8'($urandom));
    end

    // reset during the second ACCESS cycle
    mem_rdata = 8'h99;
    stb = 1'b1; wr = 1'b0; addr = 16'h0300; priv_lvl = 1'b1; dpc_ot = 16'h0001;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.mem_re_before", mem_re, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort.mem_re", mem_re, 1'b0);
    chk("abort.mem_we", mem_we, 1'b0);
    chk("abort.ack", ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack || mem_re || mem_we) n_ack++;
    end
    chk("abort.no_ack", n_ack, 0);
    m_dout = 8'd0; m_vcnt = 8'd0; m_vaddr = 16'd0; m_vpc = 16'd0;
    chk_regs("abort");
    do_req(1'b0, 16'h0400, 8'h00, 1'b0, 16'h0002, 8'h3E);
    do_req(1'b0, 16'hF123, 8'h00, 1'b0, 16'h0003, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
